// File: rtl/sd_clk_switch_ctrl_if.sv
// rtl/sd_clk_switch_ctrl_if.sv - request/status bundle between SD host logic and the clock switch controller
//
// Purpose: groups the clock-switch request inputs and the registered status outputs.
// Signals:
//   ireq_fast  requested SD clock level (1 = fast, 0 = slow)
//   ibus_idle  1 = no SD command/data transfer in progress
//   ilock      PLL lock status of the SD clock source
//   oclk_sel   clock divider select (0 = slow, 1 = fast)
//   oclk_en    SD clock output gate enable
//   obusy      switch sequence in progress
//   odone      one-cycle pulse at sequence completion
// Modports: master = host side (drives requests), slave = controller side.
interface sd_clk_switch_ctrl_if;
  logic ireq_fast;
  logic ibus_idle;
  logic ilock;
  logic oclk_sel;
  logic oclk_en;
  logic obusy;
  logic odone;

  modport master (
    output ireq_fast,
    output ibus_idle,
    output ilock,
    input  oclk_sel,
    input  oclk_en,
    input  obusy,
    input  odone
  );

  modport slave (
    input  ireq_fast,
    input  ibus_idle,
    input  ilock,
    output oclk_sel,
    output oclk_en,
    output obusy,
    output odone
  );
endinterface

// File: rtl/sd_clk_switch_ctrl.sv
// rtl/sd_clk_switch_ctrl.sv - glitch-free SD clock slow/fast switch sequencer
//
// Purpose: gates the SD clock, changes the divider select, waits for the clock
// source to settle and relock, then ungates the clock.
// Ports:
//   iclk  single rising-edge clock
//   irst  synchronous active-low reset
//   bus   sd_clk_switch_ctrl_if.slave (requests in, registered status out)
// Parameters:
//   GATE_CYCLES    cycles gated before the select changes (1..255)
//   SETTLE_CYCLES  minimum cycles gated after the select changes (1..255)
module sd_clk_switch_ctrl #(
  parameter int GATE_CYCLES   = 4,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                 iclk,
  input  logic                 irst,
  sd_clk_switch_ctrl_if.slave  bus
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_GATE   = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;

  // The counter counts down to zero, so each state lasts load+1 cycles.
  localparam logic [7:0] GATE_LOAD   = 8'(GATE_CYCLES - 1);
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  logic [1:0] state;
  logic [7:0] cnt;
  logic       target;
  logic       sel_q;
  logic       en_q;
  logic       busy_q;
  logic       done_q;

  logic       start;
  logic       cnt_expired;

  assign start       = (state == ST_RUN) && (bus.ireq_fast != sel_q) &&
                       bus.ibus_idle && bus.ilock;
  assign cnt_expired = (cnt == 8'd0);

  always_ff @(posedge iclk) begin
    if (!irst) begin
      state  <= ST_RUN;
      cnt    <= 8'd0;
      target <= 1'b0;
      sel_q  <= 1'b0;
      en_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_RUN: begin
          if (start) begin
            target <= ~sel_q;
            state  <= ST_GATE;
            cnt    <= GATE_LOAD;
            en_q   <= 1'b0;
            busy_q <= 1'b1;
          end else begin
            // Clock runs only while the source is locked; lock loss gates it in place.
            en_q   <= bus.ilock;
            cnt    <= 8'd0;
            busy_q <= 1'b0;
          end
        end

        ST_GATE: begin
          en_q <= 1'b0;
          if (cnt_expired) begin
            sel_q <= target;
            state <= ST_SETTLE;
            cnt   <= SETTLE_LOAD;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        ST_SETTLE: begin
          if (cnt_expired && bus.ilock) begin
            state  <= ST_RUN;
            cnt    <= 8'd0;
            en_q   <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            en_q <= 1'b0;
            // Hold at zero while waiting for lock rather than wrapping.
            if (!cnt_expired) begin
              cnt <= cnt - 8'd1;
            end
          end
        end

        default: begin
          state  <= ST_RUN;
          cnt    <= 8'd0;
          en_q   <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.oclk_sel = sel_q;
  assign bus.oclk_en  = en_q;
  assign bus.obusy    = busy_q;
  assign bus.odone    = done_q;

endmodule

// File: tb/tb_sd_clk_switch_ctrl.sv
// tb/tb_sd_clk_switch_ctrl.sv - testbench for sd_clk_switch_ctrl
module tb_sd_clk_switch_ctrl;

  logic iclk;
  logic irst;
  int   checks;
  int   errors;

  sd_clk_switch_ctrl_if bus ();

  sd_clk_switch_ctrl #(
    .GATE_CYCLES  (4),
    .SETTLE_CYCLES(16)
  ) dut (
    .iclk(iclk),
    .irst(irst),
    .bus (bus.slave)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  typedef struct {
    logic  rst;
    logic  req;
    logic  idle;
    logic  lock;
    int    n;
    logic  sel;
    logic  en;
    logic  busy;
    logic  done;
    string name;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(logic rst, logic req, logic idle, logic lock, int n,
                              logic sel, logic en, logic busy, logic done, string name);
    vec_t v;
    v.rst = rst; v.req = req; v.idle = idle; v.lock = lock; v.n = n;
    v.sel = sel; v.en = en; v.busy = busy; v.done = done; v.name = name;
    return v;
  endfunction

  task automatic cmp(string name, string sig, logic got, logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: %s got %b expected %b", name, sig, got, exp);
    end
  endtask

  task automatic check(string name, logic sel, logic en, logic busy, logic done);
    cmp(name, "oclk_sel", bus.oclk_sel, sel);
    cmp(name, "oclk_en",  bus.oclk_en,  en);
    cmp(name, "obusy",    bus.obusy,    busy);
    cmp(name, "odone",    bus.odone,    done);
  endtask

  // Drive inputs between edges, advance n rising edges, sample 1 time unit later.
  task automatic apply(logic rst, logic req, logic idle, logic lock, int n);
    @(negedge iclk);
    irst          = rst;
    bus.ireq_fast = req;
    bus.ibus_idle = idle;
    bus.ilock     = lock;
    repeat (n) @(posedge iclk);
    #1;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    irst          = 1'b0;
    bus.ireq_fast = 1'b0;
    bus.ibus_idle = 1'b1;
    bus.ilock     = 1'b1;

    //               rst  req  idle lock  n   sel  en   busy done
    vecs[0]  = mk(1'b0, 1'b0, 1'b1, 1'b1,  2, 1'b0, 1'b0, 1'b0, 1'b0, "reset");
    vecs[1]  = mk(1'b1, 1'b0, 1'b1, 1'b1,  2, 1'b0, 1'b1, 1'b0, 1'b0, "post_reset_run");
    vecs[2]  = mk(1'b1, 1'b1, 1'b1, 1'b1,  1, 1'b0, 1'b0, 1'b1, 1'b0, "s2f_t1");
    vecs[3]  = mk(1'b1, 1'b1, 1'b1, 1'b1,  3, 1'b0, 1'b0, 1'b1, 1'b0, "s2f_t4");
    vecs[4]  = mk(1'b1, 1'b1, 1'b1, 1'b1,  1, 1'b1, 1'b0, 1'b1, 1'b0, "s2f_t5");
    vecs[5]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 15, 1'b1, 1'b0, 1'b1, 1'b0, "s2f_t20");
    vecs[6]  = mk(1'b1, 1'b1, 1'b1, 1'b1,  1, 1'b1, 1'b1, 1'b0, 1'b1, "s2f_t21");
    vecs[7]  = mk(1'b1, 1'b1, 1'b1, 1'b1,  1, 1'b1, 1'b1, 1'b0, 1'b0, "s2f_t22");
    vecs[8]  = mk(1'b1, 1'b1, 1'b1, 1'b0,  1, 1'b1, 1'b0, 1'b0, 1'b0, "run_lock_loss");
    vecs[9]  = mk(1'b1, 1'b1, 1'b1, 1'b1,  1, 1'b1, 1'b1, 1'b0, 1'b0, "run_lock_back");
    vecs[10] = mk(1'b1, 1'b0, 1'b0, 1'b1, 50, 1'b1, 1'b1, 1'b0, 1'b0, "wait_bus_busy");
    vecs[11] = mk(1'b1, 1'b0, 1'b1, 1'b0,  3, 1'b1, 1'b0, 1'b0, 1'b0, "wait_no_lock");
    vecs[12] = mk(1'b1, 1'b0, 1'b0, 1'b1,  1, 1'b1, 1'b1, 1'b0, 1'b0, "wait_relock");
    vecs[13] = mk(1'b1, 1'b0, 1'b1, 1'b1,  1, 1'b1, 1'b0, 1'b1, 1'b0, "f2s_s1");
    vecs[14] = mk(1'b1, 1'b1, 1'b0, 1'b1,  4, 1'b0, 1'b0, 1'b1, 1'b0, "f2s_s5_ignore");
    vecs[15] = mk(1'b1, 1'b1, 1'b0, 1'b1, 15, 1'b0, 1'b0, 1'b1, 1'b0, "f2s_s20");
    vecs[16] = mk(1'b1, 1'b1, 1'b0, 1'b1,  1, 1'b0, 1'b1, 1'b0, 1'b1, "f2s_s21");
    vecs[17] = mk(1'b1, 1'b1, 1'b0, 1'b1,  1, 1'b0, 1'b1, 1'b0, 1'b0, "revert_waits");

    for (int i = 0; i < 18; i++) begin
      apply(vecs[i].rst, vecs[i].req, vecs[i].idle, vecs[i].lock, vecs[i].n);
      check(vecs[i].name, vecs[i].sel, vecs[i].en, vecs[i].busy, vecs[i].done);
    end

    // Lock lost through SETTLE expiry; relock 10 cycles after expiry (T+30).
    apply(1'b1, 1'b1, 1'b1, 1'b1, 1);
    check("relock_t1", 1'b0, 1'b0, 1'b1, 1'b0);
    apply(1'b1, 1'b1, 1'b1, 1'b1, 4);
    check("relock_t5", 1'b1, 1'b0, 1'b1, 1'b0);
    apply(1'b1, 1'b1, 1'b1, 1'b0, 16);
    check("relock_t21_wait", 1'b1, 1'b0, 1'b1, 1'b0);
    apply(1'b1, 1'b1, 1'b1, 1'b0, 9);
    check("relock_t30_wait", 1'b1, 1'b0, 1'b1, 1'b0);
    apply(1'b1, 1'b1, 1'b1, 1'b1, 1);
    check("relock_done", 1'b1, 1'b1, 1'b0, 1'b1);

    // Back-to-back: fast->slow requested on the odone cycle.
    apply(1'b1, 1'b0, 1'b1, 1'b1, 1);
    check("b2b_t1", 1'b1, 1'b0, 1'b1, 1'b0);
    apply(1'b1, 1'b0, 1'b1, 1'b1, 3);
    check("b2b_t4", 1'b1, 1'b0, 1'b1, 1'b0);
    apply(1'b1, 1'b0, 1'b1, 1'b1, 1);
    check("b2b_t5", 1'b0, 1'b0, 1'b1, 1'b0);
    apply(1'b1, 1'b0, 1'b1, 1'b1, 16);
    check("b2b_t21", 1'b0, 1'b1, 1'b0, 1'b1);

    // Reset at T+8 of a slow->fast switch aborts without odone.
    apply(1'b1, 1'b1, 1'b1, 1'b1, 8);
    check("abort_t8", 1'b1, 1'b0, 1'b1, 1'b0);
    apply(1'b0, 1'b1, 1'b1, 1'b1, 1);
    check("abort_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    begin
      logic saw_done;
      saw_done = 1'b0;
      for (int k = 0; k < 20; k++) begin
        apply(1'b1, 1'b0, 1'b1, 1'b1, 1);
        if (bus.odone) saw_done = 1'b1;
      end
      cmp("abort_no_done", "odone_seen", saw_done, 1'b0);
      check("abort_run", 1'b0, 1'b1, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_clk_switch_ctrl.md
SD_CLK_SWITCH_CTRL -- requirements
Module: sd_clk_switch_ctrl

Interface
REQ-001 Parameter GATE_CYCLES, default 4, number of iclk cycles the SD clock is gated before the select changes (legal 1..255).
REQ-002 Parameter SETTLE_CYCLES, default 16, number of iclk cycles held gated after the select changes (legal 1..255).
REQ-003 iclk  input  1  single clock, all logic rising-edge.
REQ-004 irst  input  1  reset, synchronous, active-low.
REQ-005 ireq_fast  input  1  level, requested SD clock: 1 = fast, 0 = slow.
REQ-006 ibus_idle  input  1  1 = no SD command/data transfer in progress; switching is permitted.
REQ-007 ilock  input  1  PLL lock status of the SD clock source.
REQ-008 oclk_sel  output  1  drives the clock divider select: 0 = slow, 1 = fast.
REQ-009 oclk_en  output  1  SD clock output gate enable.
REQ-010 obusy  output  1  1 while a switch sequence is in progress.
REQ-011 odone  output  1  one-cycle pulse when a switch sequence completes.

Function
REQ-012 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-013 FSM states SHALL be RUN, GATE and SETTLE.
- RUN: oclk_sel holds the current clock.
- GATE: oclk_en=0.
- SETTLE: oclk_en=0.
REQ-014 A switch SHALL start when all of the following are sampled high in RUN: ireq_fast != oclk_sel, ibus_idle=1 and ilock=1.
- On the cycle the start is sampled (T), the target value ~oclk_sel SHALL be latched.
- At T+1: state=GATE, oclk_en=0, obusy=1.
REQ-015 The FSM SHALL stay in GATE for exactly GATE_CYCLES cycles.
- On the last GATE cycle it SHALL load oclk_sel with the latched target and enter SETTLE.
- With defaults, oclk_sel changes at T+5.
REQ-016 The FSM SHALL stay in SETTLE for at least SETTLE_CYCLES cycles.
- It SHALL leave SETTLE on the first cycle with the count expired and ilock=1.
- On leaving: state=RUN, oclk_en=1, obusy=0, odone=1 for exactly one cycle.
- With defaults and lock held, this occurs at T+21.
REQ-017 If ilock=0 when the SETTLE count expires, the FSM SHALL remain in SETTLE with oclk_en=0 until ilock=1; there is no timeout.
REQ-018 Changes on ireq_fast or ibus_idle during GATE/SETTLE SHALL be ignored. A request reverted mid-sequence SHALL start a new switch after return to RUN, subject to REQ-014.
REQ-019 In RUN, oclk_en SHALL equal ilock delayed by one cycle. Loss of lock gates the clock without changing state or oclk_sel.
REQ-020 In RUN with ireq_fast != oclk_sel but ibus_idle=0 or ilock=0, the FSM SHALL wait indefinitely with obusy=0.
REQ-021 The cycle counter SHALL be 8 bits and SHALL reload on every state entry. Wrap-around SHALL never occur; the count saturates at expiry.
REQ-022 Back-to-back switches SHALL be allowed: a new start may be sampled on the same cycle odone=1.

Reset
REQ-023 With irst=0 at a rising edge, the block SHALL set:
- state=RUN
- oclk_sel=0 (slow, SD identification clock)
- oclk_en=0
- obusy=0
- odone=0
- counter=0
- latched target=0
REQ-024 The first cycle after reset release SHALL follow REQ-019: oclk_en follows ilock one cycle later.
REQ-025 Reset asserted mid-sequence SHALL abort the switch immediately to the REQ-023 values, with no odone pulse.

Verification
REQ-026 Reset, ilock=1, ireq_fast=0 -> oclk_sel=0, oclk_en=1 from the second cycle after release, obusy=0.
REQ-027 ireq_fast 0->1 at T with ibus_idle=1, ilock=1, defaults:
- oclk_en=0 and obusy=1 at T+1.
- oclk_sel=1 at T+5.
- oclk_en=1 and odone=1 at T+21.
- odone=0 at T+22.
REQ-028 ireq_fast=1 with ibus_idle=0 for 50 cycles, then ibus_idle=1 at cycle S -> no change before S; sequence as in REQ-027 relative to S.
REQ-029 ilock dropped during SETTLE and restored 10 cycles after count expiry -> oclk_en stays 0 and odone fires one cycle after ilock returns.
REQ-030 irst=0 asserted at T+8 of a slow->fast switch -> next cycle oclk_sel=0, oclk_en=0, obusy=0, no odone.
REQ-031 Fast->slow switch immediately after odone (ireq_fast=0 on the odone cycle) -> oclk_en=0 one cycle later, and oclk_sel=0 after GATE_CYCLES.
